// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the ball-balancer CPU.
// Optional macro CTRL_WAIT_HALT_EN adds a WAIT state entered by enc 15 and left on start.
module cpu_control_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [3:0] i_enc,
    input  logic       i_cond_true,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_mem_addr_sel,
    output logic       o_ir_load,
    output logic       o_pc_inc,
    output logic       o_pc_load,
    output logic [1:0] o_pc_src,
    output logic       o_reg_we,
    output logic [1:0] o_wb_sel,
    output logic       o_flags_we,
    output logic       o_busy,
    output logic       o_err,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
`ifdef CTRL_WAIT_HALT_EN
        , S_WAIT = 3'd7
`endif
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, which covers entry to FETCH and MEM.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (o_mem_req && !i_mem_ready)
                r_cnt <= r_cnt + 1'b1;
            if (w_next == S_HALT)
                r_err <= 1'b1;
        end
    end

    // Count would reach TIMEOUT this cycle; a simultaneous mem_ready still wins.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1)) && !i_mem_ready;

    always_comb begin
        w_next         = r_state;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_ir_load      = 1'b0;
        o_pc_inc       = 1'b0;
        o_pc_load      = 1'b0;
        o_pc_src       = 2'd0;
        o_reg_we       = 1'b0;
        o_wb_sel       = 2'd0;
        o_flags_we     = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_FETCH;
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_load = 1'b1;
                    o_pc_inc  = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_FETCH;
                case (i_enc)
                    4'd0, 4'd1, 4'd2, 4'd3: begin
                        o_reg_we   = 1'b1;
                        o_flags_we = 1'b1;
                    end
                    4'd4: o_flags_we = 1'b1;
                    4'd5, 4'd6, 4'd7, 4'd8, 4'd9: o_reg_we = 1'b1;
                    4'd10, 4'd11: w_next = S_MEM;
                    4'd12: if (i_cond_true) begin
                        o_pc_load = 1'b1;
                        o_pc_src  = 2'd1;
                    end
                    4'd13: if (i_cond_true) begin
                        o_pc_load = 1'b1;
                        o_pc_src  = 2'd2;
                    end
                    4'd14: begin
                        o_reg_we  = 1'b1;
                        o_wb_sel  = 2'd2;
                        o_pc_load = 1'b1;
                        o_pc_src  = 2'd2;
                    end
                    default: begin
`ifdef CTRL_WAIT_HALT_EN
                        w_next = S_WAIT;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_mem_we       = (i_enc == 4'd11);
                if (i_mem_ready)
                    w_next = (i_enc == 4'd10) ? S_WB : S_FETCH;
                else if (w_timeout)
                    w_next = S_HALT;
            end
            S_WB: begin
                o_reg_we = 1'b1;
                o_wb_sel = 2'd1;
                w_next   = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
`ifdef CTRL_WAIT_HALT_EN
            S_WAIT: if (i_start) w_next = S_FETCH;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_err   = r_err;
    assign o_state = r_state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized instruction stream against a per-instruction cycle-table model of cpu_control_fsm.
module tb_cpu_control_fsm;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] enc = 4'd0;
    logic       cond_true = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load;
    logic [1:0] pc_src, wb_sel;
    logic       reg_we, flags_we, busy, err;
    logic [2:0] state;
    logic [16:0] obs;
    int checks = 0;
    int failures = 0;

    cpu_control_fsm #(.TIMEOUT(15), .CNT_W(4)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_enc(enc),
        .i_cond_true(cond_true), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr_sel(mem_addr_sel),
        .o_ir_load(ir_load), .o_pc_inc(pc_inc), .o_pc_load(pc_load), .o_pc_src(pc_src),
        .o_reg_we(reg_we), .o_wb_sel(wb_sel), .o_flags_we(flags_we),
        .o_busy(busy), .o_err(err), .o_state(state)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load, pc_src,
                  reg_we, wb_sel, flags_we, busy, err, state};

    function automatic logic [16:0] ev(input logic req, we, asel, irl, pci, pcl,
                                       input logic [1:0] pcs, input logic rwe,
                                       input logic [1:0] wbs, input logic fwe, bsy, er,
                                       input logic [2:0] st);
        return {req, we, asel, irl, pci, pcl, pcs, rwe, wbs, fwe, bsy, er, st};
    endfunction

    task automatic chk(input string tag, input logic [16:0] e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, e);
        end
    endtask

    // Called at posedge+1: drive mem_ready, check mid-cycle, advance one clock.
    task automatic step(input string tag, input logic rdy, input logic [16:0] e);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, e);
        @(posedge clk);
        #1;
    endtask

    // Expected cycle table for one instruction, from FETCH until the next FETCH.
    task automatic do_instr(input logic [3:0] e, input logic c, input int fw, input int mw);
        logic jump, rwe, fwe;
        logic [1:0] pcs, wbs;
        enc = e;
        cond_true = c;
        for (int i = 0; i < fw; i++)
            step("fetch_wait", 1'b0, ev(1,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd1));
        step("fetch", 1'b1, ev(1,0,0,1,1,0,2'd0,0,2'd0,0,1,0,3'd1));
        step("decode", 1'($urandom_range(0,1)), ev(0,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd2));
        jump = ((e == 4'd12 || e == 4'd13) && c) || e == 4'd14;
        pcs  = !jump ? 2'd0 : (e == 4'd12) ? 2'd1 : 2'd2;
        rwe  = (e <= 4'd3) || (e >= 4'd5 && e <= 4'd9) || e == 4'd14;
        fwe  = (e <= 4'd4);
        wbs  = (e == 4'd14) ? 2'd2 : 2'd0;
        step("exec", 1'($urandom_range(0,1)), ev(0,0,0,0,0,jump,pcs,rwe,wbs,fwe,1,0,3'd3));
        if (e == 4'd10 || e == 4'd11) begin
            for (int i = 0; i < mw; i++)
                step("mem_wait", 1'b0, ev(1,e==4'd11,1,0,0,0,2'd0,0,2'd0,0,1,0,3'd4));
            step("mem", 1'b1, ev(1,e==4'd11,1,0,0,0,2'd0,0,2'd0,0,1,0,3'd4));
            if (e == 4'd10)
                step("wb", 1'($urandom_range(0,1)), ev(0,0,0,0,0,0,2'd0,1,2'd1,0,1,0,3'd5));
        end
`ifdef CTRL_WAIT_HALT_EN
        if (e == 4'd15) begin
            step("wait_hold", 1'b1, ev(0,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd7));
            start = 1'b1;
            step("wait_go", 1'b0, ev(0,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd7));
            start = 1'b0;
        end
`endif
    endtask

    task automatic boot();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start = 1'b1;
        step("idle_start", 1'b1, 17'd0);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 17'd0);
        reset_n = 1'b1;
        step("idle_nostart", 1'b1, 17'd0);
        start = 1'b1;
        step("idle_start", 1'b0, 17'd0);
        start = 1'b0;

        // Directed instructions
        do_instr(4'd0, 1'b0, 0, 0);
        do_instr(4'd10, 1'b0, 0, 2);
        do_instr(4'd11, 1'b0, 1, 0);
        do_instr(4'd12, 1'b1, 0, 0);
        do_instr(4'd12, 1'b0, 0, 0);
        do_instr(4'd14, 1'b0, 0, 0);
        do_instr(4'd13, 1'b1, 2, 0);
        do_instr(4'd13, 1'b0, 0, 0);
        do_instr(4'd4, 1'b1, 0, 0);
        do_instr(4'd9, 1'b0, 0, 0);
        do_instr(4'd15, 1'b0, 0, 0);

        // Random instruction stream, waits well under the timeout
        repeat (60)
            do_instr(4'($urandom_range(0,15)), 1'($urandom_range(0,1)),
                     int'($urandom_range(0,3)), int'($urandom_range(0,3)));

        // ready on the 15th FETCH cycle still completes
        do_instr(4'd0, 1'b0, 14, 0);

        // 15 FETCH cycles without ready -> HALT, start ignored
        for (int i = 0; i < 15; i++)
            step("timeout_wait", 1'b0, ev(1,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd1));
        start = 1'b1;
        for (int i = 0; i < 3; i++)
            step("halt", 1'b1, ev(0,0,0,0,0,0,2'd0,0,2'd0,0,1,1,3'd6));
        start = 1'b0;

        // Reset out of HALT, then MEM timeout with ready on the last allowed cycle
        reset_n = 1'b0;
        #1;
        chk("reset_from_halt", 17'd0);
        boot();
        do_instr(4'd11, 1'b0, 0, 14);

        // Reset asserted mid-MEM
        enc = 4'd10;
        step("fetch", 1'b1, ev(1,0,0,1,1,0,2'd0,0,2'd0,0,1,0,3'd1));
        step("decode", 1'b0, ev(0,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd2));
        step("exec", 1'b0, ev(0,0,0,0,0,0,2'd0,0,2'd0,0,1,0,3'd3));
        step("mem_wait", 1'b0, ev(1,0,1,0,0,0,2'd0,0,2'd0,0,1,0,3'd4));
        mem_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_mem", 17'd0);
        boot();
        do_instr(4'd5, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control state machine that sequences fetch, decode, execute, memory access and write-back for the ball-balancer CPU. It consumes the 4-bit encoded operation from the opcode encoder, the branch condition result and the memory ready handshake. It drives the PC, instruction register, register file, flag register and memory strobes. It sits between the instruction/data memory port and the ALU/register-file datapath.

## Interface
- TIMEOUT, 15: max cycles `mem_req` may wait for `mem_ready` before the error trap.
- CNT_W, 4: width of the timeout counter; must hold TIMEOUT.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE (and WAIT when compiled in).
- enc  in  4  encoded operation of the current IR: 0 ADD, 1 ADDU, 2 MUL, 3 SUB, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 MOV, 9 LSH, 10 LOAD, 11 STOR, 12 BCOND, 13 JCOND, 14 JAL, 15 WAIT/NOP.
- cond_true  in  1  condition code satisfied for the current IR.
- mem_ready  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request, held until `mem_ready`.
- mem_we  out  1  write strobe qualifier, valid with `mem_req`.
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = register.
- ir_load  out  1  capture read data into IR.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= `pc_src` target.
- pc_src  out  2  PC target: 1 = PC+displacement, 2 = register.
- reg_we  out  1  register-file write.
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory data register, 2 = PC (link).
- flags_we  out  1  flag register update.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky memory-timeout error.
- state  out  3  current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, WAIT=7 (WAIT exists only with the macro).
- **IDLE**: all strobes low. `start`=1 -> FETCH.
- **FETCH**: `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0. In the cycle `mem_ready`=1, assert `ir_load` and `pc_inc` and go to DECODE. Otherwise stay in FETCH.
- **DECODE**: no strobes; one cycle for `enc` to settle from the new IR. Then go to EXEC.
- **EXEC**, decoded on `enc`:
  - enc 0–3: `reg_we`, `flags_we`, `wb_sel`=0 -> FETCH.
  - enc 4 (CMP): `flags_we` only -> FETCH.
  - enc 5–9: `reg_we`, `wb_sel`=0 -> FETCH.
  - enc 10 (LOAD) or 11 (STOR): go to MEM.
  - enc 12 (BCOND): if `cond_true`, `pc_load` with `pc_src`=1 -> FETCH.
  - enc 13 (JCOND): if `cond_true`, `pc_load` with `pc_src`=2 -> FETCH.
  - enc 14 (JAL): `reg_we` with `wb_sel`=2, plus `pc_load` with `pc_src`=2, in the same cycle -> FETCH.
  - enc 15: NOP -> FETCH (see Configuration).
- **MEM**: `mem_req`=1, `mem_addr_sel`=1, `mem_we` = (enc==11). On `mem_ready`: LOAD goes to WB; STOR goes to FETCH.
- **WB**: `reg_we`, `wb_sel`=1 -> FETCH. The external MDR captures read data on `mem_ready`.
- **HALT**: all strobes low, `err`=1. Only reset exits HALT; `start` is ignored.
- **Timeout**:
  - The counter clears on entry to FETCH or MEM and increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - When count reaches TIMEOUT without `mem_ready`, go to HALT and set `err`.
  - `mem_ready` arriving in the same cycle the count reaches TIMEOUT wins: the transfer completes normally.
- `mem_ready` is ignored in any state that is not requesting memory.

## Timing
- State, counter and `err` are registered. All strobes are combinational decodes of state, `enc`, `cond_true` and `mem_ready`, lasting exactly one cycle except `mem_req`.
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE, counter=0, `err`=0.
  - Every output is 0 while `reset_n`=0; `state` reads 0.
  - An in-flight `mem_req` drops immediately.
- Minimum latency with zero-wait memory (FETCH→next FETCH):
  - ALU, branch and JAL instructions: 3 cycles.
  - STOR: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds one cycle.
- `mem_req` rises on state entry and falls the cycle after `mem_ready` is sampled high.

## Configuration
- `CTRL_WAIT_HALT_EN` defined:
  - enc 15 in EXEC goes to WAIT, with all strobes low and `busy`=1.
  - `start`=1 in WAIT -> FETCH.
- `CTRL_WAIT_HALT_EN` undefined:
  - WAIT state is absent and enc 15 is a one-cycle NOP returning to FETCH.
  - State encoding 7 is unreachable.

## Test plan
- Reset, `start` pulse, ADD (enc 0) with `mem_ready` tied high -> `ir_load`/`pc_inc` in cycle 1, `reg_we`+`flags_we`+`wb_sel`=0 in cycle 3, back to FETCH in cycle 4.
- LOAD (enc 10) with 2 wait cycles in MEM -> `mem_addr_sel`=1, `mem_we`=0 held 3 cycles, then WB with `reg_we`, `wb_sel`=1; STOR (enc 11) -> `mem_we`=1 and no `reg_we`.
- BCOND (enc 12) with `cond_true`=1 -> `pc_load`, `pc_src`=1; with `cond_true`=0 -> no `pc_load`; JAL (enc 14) -> `reg_we`, `wb_sel`=2, `pc_load`, `pc_src`=2 in the same cycle.
- `mem_ready` held low in FETCH with TIMEOUT=15 -> HALT after 15 cycles with `err`=1, then `start` ignored; `mem_ready` on cycle 15 instead -> normal DECODE.
- `reset_n` asserted mid-MEM -> all outputs 0 asynchronously, state=0, `err`=0.
- enc 15 -> with the macro, WAIT holds until `start` then FETCH; without the macro, FETCH on the next cycle.
